// File: rtl/id_ex_stage_if.sv
// Signal bundle between the decode stage, the ID/EX pipeline register and the EX stage.
// The slave side is the ID/EX register; the master side is the surrounding pipeline.
interface id_ex_stage_if;
  logic        stall;
  logic        flush;
  logic        idValid;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] immExt;
  logic [4:0]  rsAddr;
  logic [4:0]  rtAddr;
  logic [4:0]  rdAddr;
  logic        idUsesRt;
  logic [3:0]  AluControlIn;
  logic [4:0]  shamtIn;
  logic        aluSrcIn;
  logic        regDstIn;
  logic        regWriteIn;
  logic        memReadIn;
  logic        memWriteIn;
  logic        memToRegIn;
  logic        exMemRegWrite;
  logic [4:0]  exMemRd;
  logic [31:0] exMemAluOut;
  logic        memWbRegWrite;
  logic [4:0]  memWbRd;
  logic [31:0] memWbData;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic [3:0]  AluControl;
  logic [4:0]  shamt;
  logic [31:0] storeData;
  logic [4:0]  writeReg;
  logic        exValid;
  logic        regWrite;
  logic        memRead;
  logic        memWrite;
  logic        memToReg;
  logic        loadUseStall;

  modport slave (
    input  stall, flush, idValid, rsData, rtData, immExt,
           rsAddr, rtAddr, rdAddr, idUsesRt,
           AluControlIn, shamtIn, aluSrcIn, regDstIn,
           regWriteIn, memReadIn, memWriteIn, memToRegIn,
           exMemRegWrite, exMemRd, exMemAluOut,
           memWbRegWrite, memWbRd, memWbData,
    output inputA, inputB, AluControl, shamt, storeData, writeReg,
           exValid, regWrite, memRead, memWrite, memToReg, loadUseStall
  );

  modport master (
    output stall, flush, idValid, rsData, rtData, immExt,
           rsAddr, rtAddr, rdAddr, idUsesRt,
           AluControlIn, shamtIn, aluSrcIn, regDstIn,
           regWriteIn, memReadIn, memWriteIn, memToRegIn,
           exMemRegWrite, exMemRd, exMemAluOut,
           memWbRegWrite, memWbRd, memWbData,
    input  inputA, inputB, AluControl, shamt, storeData, writeReg,
           exValid, regWrite, memRead, memWrite, memToReg, loadUseStall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
// One clock from decode to ALU operands; forwarding muxes are combinational on the registered fields.
module id_ex_stage (
  input logic             clk,
  input logic             reset,
  id_ex_stage_if.slave    bus
);
  logic        r_valid;
  logic [31:0] r_rsData;
  logic [31:0] r_rtData;
  logic [31:0] r_immExt;
  logic [4:0]  r_rsAddr;
  logic [4:0]  r_rtAddr;
  logic [3:0]  r_AluControl;
  logic [4:0]  r_shamt;
  logic        r_aluSrc;
  logic [4:0]  r_writeReg;
  logic        r_regWrite;
  logic        r_memRead;
  logic        r_memWrite;
  logic        r_memToReg;

  logic        w_loadUseStall;
  logic [31:0] w_fwdA;
  logic [31:0] w_fwdB;

  // Compares against the registered load's rt and the live decode specifiers.
  assign w_loadUseStall = r_valid && r_memRead && (r_rtAddr != '0) &&
                          ((r_rtAddr == bus.rsAddr) ||
                           (bus.idUsesRt && (r_rtAddr == bus.rtAddr)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_rsData     <= '0;
      r_rtData     <= '0;
      r_immExt     <= '0;
      r_rsAddr     <= '0;
      r_rtAddr     <= '0;
      r_AluControl <= '0;
      r_shamt      <= '0;
      r_aluSrc     <= 1'b0;
      r_writeReg   <= '0;
      r_regWrite   <= 1'b0;
      r_memRead    <= 1'b0;
      r_memWrite   <= 1'b0;
      r_memToReg   <= 1'b0;
    end else if (bus.flush || (!bus.stall && w_loadUseStall)) begin
      // Bubble: only side-effecting controls are cleared; data fields are don't-care.
      r_valid    <= 1'b0;
      r_regWrite <= 1'b0;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      r_memToReg <= 1'b0;
    end else if (!bus.stall) begin
      r_valid      <= bus.idValid;
      r_rsData     <= bus.rsData;
      r_rtData     <= bus.rtData;
      r_immExt     <= bus.immExt;
      r_rsAddr     <= bus.rsAddr;
      r_rtAddr     <= bus.rtAddr;
      r_AluControl <= bus.AluControlIn;
      r_shamt      <= bus.shamtIn;
      r_aluSrc     <= bus.idValid && bus.aluSrcIn;
      r_writeReg   <= bus.regDstIn ? bus.rdAddr : bus.rtAddr;
      r_regWrite   <= bus.idValid && bus.regWriteIn;
      r_memRead    <= bus.idValid && bus.memReadIn;
      r_memWrite   <= bus.idValid && bus.memWriteIn;
      r_memToReg   <= bus.idValid && bus.memToRegIn;
    end
  end

  always_comb begin
    w_fwdA = r_rsData;
    if (bus.exMemRegWrite && (bus.exMemRd != '0) && (bus.exMemRd == r_rsAddr))
      w_fwdA = bus.exMemAluOut;
    else if (bus.memWbRegWrite && (bus.memWbRd != '0) && (bus.memWbRd == r_rsAddr))
      w_fwdA = bus.memWbData;
  end

  always_comb begin
    w_fwdB = r_rtData;
    if (bus.exMemRegWrite && (bus.exMemRd != '0) && (bus.exMemRd == r_rtAddr))
      w_fwdB = bus.exMemAluOut;
    else if (bus.memWbRegWrite && (bus.memWbRd != '0) && (bus.memWbRd == r_rtAddr))
      w_fwdB = bus.memWbData;
  end

  assign bus.inputA       = w_fwdA;
  assign bus.inputB       = r_aluSrc ? r_immExt : w_fwdB;
  assign bus.storeData    = w_fwdB;
  assign bus.AluControl   = r_AluControl;
  assign bus.shamt        = r_shamt;
  assign bus.writeReg     = r_writeReg;
  assign bus.exValid      = r_valid;
  assign bus.regWrite     = r_regWrite;
  assign bus.memRead      = r_memRead;
  assign bus.memWrite     = r_memWrite;
  assign bus.memToReg     = r_memToReg;
  assign bus.loadUseStall = w_loadUseStall;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, immediates, forwarding, load-use, stall/flush, reset.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic reset;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".inputA"},     bus.inputA, 32'd0);
    chk({tag, ".inputB"},     bus.inputB, 32'd0);
    chk({tag, ".AluControl"}, 32'(bus.AluControl), 32'd0);
    chk({tag, ".shamt"},      32'(bus.shamt), 32'd0);
    chk({tag, ".writeReg"},   32'(bus.writeReg), 32'd0);
    chk({tag, ".exValid"},    32'(bus.exValid), 32'd0);
    chk({tag, ".regWrite"},   32'(bus.regWrite), 32'd0);
    chk({tag, ".memRead"},    32'(bus.memRead), 32'd0);
    chk({tag, ".memWrite"},   32'(bus.memWrite), 32'd0);
    chk({tag, ".memToReg"},   32'(bus.memToReg), 32'd0);
    chk({tag, ".loadUse"},    32'(bus.loadUseStall), 32'd0);
  endtask

  task automatic clear_decode();
    bus.idValid = 0; bus.rsData = 0; bus.rtData = 0; bus.immExt = 0;
    bus.rsAddr = 0; bus.rtAddr = 0; bus.rdAddr = 0; bus.idUsesRt = 0;
    bus.AluControlIn = 0; bus.shamtIn = 0; bus.aluSrcIn = 0; bus.regDstIn = 0;
    bus.regWriteIn = 0; bus.memReadIn = 0; bus.memWriteIn = 0; bus.memToRegIn = 0;
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 0; bus.flush = 0;
    clear_decode();
    bus.exMemRegWrite = 0; bus.exMemRd = 0; bus.exMemAluOut = 0;
    bus.memWbRegWrite = 0; bus.memWbRd = 0; bus.memWbData = 0;
    tick(); tick();
    chk_reset_state("rst");
    reset = 1'b0;

    // Pass-through
    bus.idValid = 1; bus.rsData = 789; bus.rtData = 5; bus.immExt = 90;
    bus.rsAddr = 1; bus.rtAddr = 2; bus.rdAddr = 3; bus.regDstIn = 1;
    bus.regWriteIn = 1; bus.AluControlIn = 4'b0000;
    tick();
    chk("pt.inputA", bus.inputA, 32'd789);
    chk("pt.inputB", bus.inputB, 32'd5);
    chk("pt.alu", 32'(bus.AluControl), 32'd0);
    chk("pt.exValid", 32'(bus.exValid), 32'd1);
    chk("pt.writeReg", 32'(bus.writeReg), 32'd3);
    chk("pt.regWrite", 32'(bus.regWrite), 32'd1);

    // Immediate / shift, regDst=0 selects rt
    bus.aluSrcIn = 1; bus.shamtIn = 3; bus.AluControlIn = 4'b0011; bus.regDstIn = 0;
    tick();
    chk("imm.inputB", bus.inputB, 32'd90);
    chk("imm.shamt", 32'(bus.shamt), 32'd3);
    chk("imm.alu", 32'(bus.AluControl), 32'd3);
    chk("imm.store", bus.storeData, 32'd5);
    chk("imm.writeReg", 32'(bus.writeReg), 32'd2);

    // Double forward on rs
    bus.aluSrcIn = 0; bus.rsAddr = 8; bus.rsData = 11;
    tick();
    bus.exMemRegWrite = 1; bus.exMemRd = 8; bus.exMemAluOut = 777;
    bus.memWbRegWrite = 1; bus.memWbRd = 8; bus.memWbData = 85;
    #1 chk("fwd.both", bus.inputA, 32'd777);
    bus.exMemRegWrite = 0;
    #1 chk("fwd.memwb", bus.inputA, 32'd85);
    bus.memWbRegWrite = 0;
    #1 chk("fwd.none", bus.inputA, 32'd11);

    // Register 0 is never forwarded; rt path forwards from EX/MEM
    bus.exMemRegWrite = 0; bus.memWbRegWrite = 0;
    bus.rsAddr = 0; bus.rsData = 44; bus.rtAddr = 8; bus.rtData = 6;
    tick();
    bus.exMemRegWrite = 1; bus.exMemRd = 0; bus.exMemAluOut = 321;
    bus.memWbRegWrite = 1; bus.memWbRd = 0; bus.memWbData = 654;
    #1 chk("r0.inputA", bus.inputA, 32'd44);
    chk("r0.inputB", bus.inputB, 32'd6);
    bus.exMemRd = 8; bus.memWbRd = 8;
    #1 chk("fwdB.inputB", bus.inputB, 32'd321);
    chk("fwdB.store", bus.storeData, 32'd321);
    chk("fwdB.inputA", bus.inputA, 32'd44);
    bus.exMemRegWrite = 0; bus.memWbRegWrite = 0;

    // Load-use via rs
    clear_decode();
    bus.idValid = 1; bus.rsAddr = 1; bus.rtAddr = 9; bus.memReadIn = 1;
    bus.memToRegIn = 1; bus.regWriteIn = 1;
    tick();
    chk("lw.memRead", 32'(bus.memRead), 32'd1);
    bus.memReadIn = 0; bus.memToRegIn = 0;
    bus.rsAddr = 9; bus.rtAddr = 4; bus.idUsesRt = 1;
    #1 chk("lu.rs", 32'(bus.loadUseStall), 32'd1);
    tick();
    chk("lu.bub.exValid", 32'(bus.exValid), 32'd0);
    chk("lu.bub.regWrite", 32'(bus.regWrite), 32'd0);
    chk("lu.bub.clear", 32'(bus.loadUseStall), 32'd0);

    // Load-use via rt only counts when the instruction reads rt
    bus.rsAddr = 1; bus.rtAddr = 9; bus.memReadIn = 1; bus.idUsesRt = 0;
    tick();
    bus.memReadIn = 0; bus.rsAddr = 4; bus.rtAddr = 9; bus.idUsesRt = 0;
    #1 chk("lu.rt.nouse", 32'(bus.loadUseStall), 32'd0);
    bus.idUsesRt = 1;
    #1 chk("lu.rt.use", 32'(bus.loadUseStall), 32'd1);

    // Stall hold for three cycles
    bus.idUsesRt = 0; bus.rsAddr = 5; bus.rtAddr = 6; bus.rdAddr = 7; bus.regDstIn = 1;
    bus.rsData = 100; bus.rtData = 200; bus.AluControlIn = 4'd5; bus.regWriteIn = 1;
    tick();
    chk("st.load", bus.inputA, 32'd100);
    bus.stall = 1; bus.rsData = 1; bus.rtData = 2; bus.AluControlIn = 4'hF; bus.rdAddr = 12;
    tick(); tick(); tick();
    chk("st.inputA", bus.inputA, 32'd100);
    chk("st.inputB", bus.inputB, 32'd200);
    chk("st.alu", 32'(bus.AluControl), 32'd5);
    chk("st.writeReg", 32'(bus.writeReg), 32'd7);
    chk("st.exValid", 32'(bus.exValid), 32'd1);
    bus.flush = 1;
    tick();
    chk("stfl.exValid", 32'(bus.exValid), 32'd0);
    chk("stfl.regWrite", 32'(bus.regWrite), 32'd0);
    bus.stall = 0; bus.idValid = 1;
    tick();
    chk("fl.exValid", 32'(bus.exValid), 32'd0);
    bus.flush = 0;

    // Reset overrides stall and a pending hazard
    clear_decode();
    bus.idValid = 1; bus.rsAddr = 2; bus.rtAddr = 9; bus.rsData = 55; bus.rtData = 66;
    bus.memReadIn = 1; bus.regWriteIn = 1; bus.memToRegIn = 1; bus.AluControlIn = 4'd2;
    bus.shamtIn = 4; bus.regDstIn = 0;
    tick();
    chk("mid.exValid", 32'(bus.exValid), 32'd1);
    bus.rsAddr = 9;
    #1 chk("mid.hazard", 32'(bus.loadUseStall), 32'd1);
    bus.stall = 1; reset = 1;
    tick();
    chk_reset_state("midrst");
    reset = 0; bus.stall = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: reset  in  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 SHALL have: stall  in  1  hold all stage registers (downstream not ready).
REQ-004 SHALL have: flush  in  1  load a bubble (branch/jump squash).
REQ-005 SHALL have: idValid  in  1  decode slot holds a real instruction.
REQ-006 SHALL have: rsData, rtData  in  32 each  register-file read data; immExt  in  32  sign/zero-extended immediate.
REQ-007 SHALL have: rsAddr, rtAddr, rdAddr  in  5 each  decode register specifiers; idUsesRt  in  1  instruction reads rt.
REQ-008 SHALL have: AluControlIn  in  4; shamtIn  in  5; aluSrcIn, regDstIn, regWriteIn, memReadIn, memWriteIn, memToRegIn  in  1 each.
REQ-009 SHALL have: exMemRegWrite  in  1; exMemRd  in  5; exMemAluOut  in  32  EX/MEM forward source.
REQ-010 SHALL have: memWbRegWrite  in  1; memWbRd  in  5; memWbData  in  32  MEM/WB forward source.
REQ-011 SHALL have: inputA, inputB  out  32 each  ALU operands; AluControl  out  4; shamt  out  5.
REQ-012 SHALL have: storeData  out  32  forwarded rt for stores; writeReg  out  5  destination register.
REQ-013 SHALL have: exValid, regWrite, memRead, memWrite, memToReg  out  1 each; loadUseStall  out  1  hazard request to IF/ID.

Function
REQ-014 Registered fields SHALL be: valid, rsData, rtData, immExt, rsAddr, rtAddr, AluControl, shamt, aluSrc, writeReg, regWrite, memRead, memWrite, memToReg.
REQ-015 writeReg SHALL capture regDstIn ? rdAddr : rtAddr.
REQ-016 Per rising edge, priority SHALL be: reset > flush > stall (hold) > loadUseStall (bubble) > load from decode.
REQ-017 Bubble SHALL clear valid, regWrite, memRead, memWrite, memToReg; data/address fields may keep any value.
REQ-018 Load SHALL capture all inputs, valid <= idValid; with idValid=0 all control bits SHALL capture 0.
REQ-019 loadUseStall SHALL be combinational: exValid & memRead & rtReg!=0 & (rtReg==rsAddr | (idUsesRt & rtReg==idRtAddr)), where rtReg is registered rtAddr and idRtAddr is input rtAddr.
REQ-020 Forwarded A SHALL be: exMemAluOut if exMemRegWrite & exMemRd!=0 & exMemRd==rsReg; else memWbData if memWbRegWrite & memWbRd!=0 & memWbRd==rsReg; else registered rsData.
REQ-021 Forwarded B SHALL follow REQ-020 using rtReg and registered rtData; EX/MEM SHALL win when both match.
REQ-022 inputA SHALL equal forwarded A; inputB SHALL be aluSrc ? immExt : forwarded B; storeData SHALL always be forwarded B.
REQ-023 Forwarding SHALL be combinational, same cycle as forward inputs; latency decode-to-ALU SHALL be one clock.
REQ-024 Register 0 SHALL never be forwarded; its registered value passes unchanged.
REQ-025 During stall, outputs SHALL stay stable except where forward inputs change; loadUseStall SHALL keep evaluating.
REQ-026 flush and stall together SHALL produce a bubble.

Reset
REQ-027 On reset all registered fields SHALL be 0: inputA=0, inputB=0, AluControl=0, shamt=0, writeReg=0, all control outputs and exValid=0, loadUseStall=0.
REQ-028 reset asserted mid-stall or mid-hazard SHALL override both and yield the reset state next edge.

Verification
REQ-029 Pass-through: load rsData=789, rtData=5, aluSrc=0, AluControlIn=0000, no forwards -> next cycle inputA=789, inputB=5, AluControl=0000, exValid=1.
REQ-030 Immediate/shift: aluSrc=1, immExt=90, shamtIn=3, AluControlIn=0011 -> inputB=90, shamt=3, storeData=rtData.
REQ-031 Double forward: rsReg=8, exMemRd=8 (777), memWbRd=8 (85), both regWrite=1 -> inputA=777; drop exMemRegWrite -> inputA=85; rd=0 matches -> no forward.
REQ-032 Load-use: registered lw memRead=1, rtReg=9; decode rsAddr=9 -> loadUseStall=1, next edge bubble (exValid=0, regWrite=0); with idUsesRt=0 and only rtAddr=9 -> loadUseStall=0.
REQ-033 Stall/flush: stall held 3 cycles -> outputs unchanged; stall+flush same edge -> bubble; flush with idValid=1 -> exValid=0.
REQ-034 Reset mid-operation: valid instruction registered, stall=1, reset=1 one edge -> all outputs 0 per REQ-027.
